// File: rtl/icb_arbiter_mux.sv
// rtl/icb_arbiter_mux.sv - per-command ICB arbiter for NUM_RD read channels plus one write channel
// Responses are routed back through an in-order tag FIFO of up to OUTST_DEPTH outstanding commands.
module icb_arbiter_mux #(
    parameter int NUM_RD      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4,
    parameter int WR_PRIO     = 1,
    localparam int CNT_W      = $clog2(OUTST_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_req_vld,
    output logic [NUM_RD-1:0]        rd_req_rdy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr,
    output logic [NUM_RD-1:0]        rd_rsp_vld,
    input  logic [NUM_RD-1:0]        rd_rsp_rdy,
    output logic [DATA_W-1:0]        rd_rsp_data,
    output logic                     rd_rsp_err,
    input  logic                     wr_req_vld,
    output logic                     wr_req_rdy,
    input  logic [ADDR_W-1:0]        wr_req_addr,
    input  logic [DATA_W-1:0]        wr_req_data,
    output logic                     wr_done,
    output logic                     icb_cmd_valid,
    input  logic                     icb_cmd_ready,
    output logic [ADDR_W-1:0]        icb_cmd_addr,
    output logic                     icb_cmd_read,
    output logic [DATA_W-1:0]        icb_cmd_wdata,
    output logic [DATA_W/8-1:0]      icb_cmd_wmask,
    input  logic                     icb_rsp_valid,
    output logic                     icb_rsp_ready,
    input  logic                     icb_rsp_err,
    input  logic [DATA_W-1:0]        icb_rsp_rdata,
    output logic [CNT_W-1:0]         outst_cnt,
    output logic                     err_sticky
);

    localparam int RR_N  = (WR_PRIO != 0) ? NUM_RD : NUM_RD + 1;
    localparam int TAG_W = $clog2(NUM_RD + 1);
    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam logic [TAG_W-1:0] WR_TAG = TAG_W'(NUM_RD);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] gnt_q, gnt_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0] tag_mem_q [OUTST_DEPTH];

    logic [NUM_RD:0]  req;
    logic [TAG_W-1:0] rr_idx, hi_idx, lo_idx, gnt_idx, head;
    logic             hi_vld, lo_vld, gnt_vld, gnt_is_wr, head_is_wr;
    logic             full, empty, cmd_fire, rsp_fire, head_rdy;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic [PTR_W:0]   cnt;

    assign req   = {wr_req_vld, rd_req_vld};
    assign cnt   = wr_ptr_q - rd_ptr_q;
    assign full  = cnt[PTR_W];
    assign empty = (cnt == '0);
    assign head  = tag_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_is_wr = (head == WR_TAG);

    // Round-robin: requesters at or above the pointer beat those below it; lowest index wins within each half.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = RR_N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (TAG_W'(i) >= rr_ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = TAG_W'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = TAG_W'(i);
                end
            end
        end
        rr_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        if (lock_q) begin
            gnt_idx = gnt_q;
        end else if ((WR_PRIO != 0) && wr_req_vld) begin
            gnt_idx = WR_TAG;
        end else begin
            gnt_idx = rr_idx;
        end
        gnt_vld   = req[gnt_idx];
        gnt_is_wr = (gnt_idx == WR_TAG);
    end

    // Valid is forced low in reset so nothing escapes before the FIFO is known empty.
    assign icb_cmd_valid = rst_n & gnt_vld & ~full;
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
    assign icb_cmd_read  = ~gnt_is_wr;
    assign icb_cmd_addr  = gnt_is_wr ? wr_req_addr : rd_addr_sel;
    assign icb_cmd_wdata = gnt_is_wr ? wr_req_data : '0;
    assign icb_cmd_wmask = gnt_is_wr ? '1 : '0;
    assign wr_req_rdy    = cmd_fire & gnt_is_wr;

    always_comb begin
        rd_addr_sel = '0;
        rd_req_rdy  = '0;
        rd_rsp_vld  = '0;
        head_rdy    = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (gnt_idx == TAG_W'(i)) begin
                rd_addr_sel   = rd_req_addr[i*ADDR_W +: ADDR_W];
                rd_req_rdy[i] = cmd_fire;
            end
            if (!empty && head == TAG_W'(i)) begin
                rd_rsp_vld[i] = icb_rsp_valid;
                head_rdy      = rd_rsp_rdy[i];
            end
        end
    end

    assign icb_rsp_ready = ~empty & (head_is_wr | head_rdy);
    assign rsp_fire      = icb_rsp_valid & icb_rsp_ready;
    assign wr_done       = rsp_fire & head_is_wr;
    assign rd_rsp_data   = icb_rsp_rdata;
    assign rd_rsp_err    = icb_rsp_err;
    assign outst_cnt     = CNT_W'(cnt);
    assign err_sticky    = err_q;

    always_comb begin
        lock_d   = icb_cmd_valid & ~icb_cmd_ready;
        gnt_d    = gnt_idx;
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | (rsp_fire & icb_rsp_err);
        if (cmd_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // A priority write bypasses the rotation, so it leaves the read pointer alone.
            if (!((WR_PRIO != 0) && gnt_is_wr)) begin
                rr_ptr_d = (gnt_idx == TAG_W'(RR_N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
        if (rsp_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            tag_mem_q[wr_ptr_q[PTR_W-1:0]] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_icb_arbiter_mux.sv
// tb/tb_icb_arbiter_mux.sv - directed self-checking bench for icb_arbiter_mux
module tb_icb_arbiter_mux;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_req_vld;
    logic [1:0]  rd_req_rdy;
    logic [63:0] rd_req_addr;
    logic [1:0]  rd_rsp_vld;
    logic [1:0]  rd_rsp_rdy;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_err;
    logic        wr_req_vld;
    logic        wr_req_rdy;
    logic [31:0] wr_req_addr;
    logic [31:0] wr_req_data;
    logic        wr_done;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic [2:0]  outst_cnt;
    logic        err_sticky;

    int checks;
    int failures;

    icb_arbiter_mux #(
        .NUM_RD(2), .ADDR_W(32), .DATA_W(32), .OUTST_DEPTH(4), .WR_PRIO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy), .rd_rsp_data(rd_rsp_data),
        .rd_rsp_err(rd_rsp_err),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_done(wr_done),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .outst_cnt(outst_cnt), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        rd_req_vld    = 2'b01;
        rd_req_addr   = {32'h0000_0200, 32'h0000_0100};
        rd_rsp_rdy    = 2'b11;
        wr_req_vld    = 1'b0;
        wr_req_addr   = 32'h0000_0300;
        wr_req_data   = 32'h1234_5678;
        icb_cmd_ready = 1'b1;
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        icb_rsp_rdata = 32'h0;

        // reset state, with a request already pending
        #12;
        chk("rst_cmd_valid", icb_cmd_valid, 0);
        chk("rst_rd_rdy", rd_req_rdy, 0);
        chk("rst_outst", outst_cnt, 0);
        chk("rst_rsp_ready", icb_rsp_ready, 0);
        chk("rst_err", err_sticky, 0);
        rd_req_vld = 2'b00;
        #1 rst_n = 1'b1;

        // single read
        tick();
        rd_req_vld = 2'b01;
        #1;
        chk("rd_valid", icb_cmd_valid, 1);
        chk("rd_addr", icb_cmd_addr, 32'h100);
        chk("rd_read", icb_cmd_read, 1);
        chk("rd_wmask", icb_cmd_wmask, 0);
        chk("rd_rdy", rd_req_rdy, 2'b01);
        tick();
        rd_req_vld = 2'b00;
        #1;
        chk("rd_outst1", outst_cnt, 1);
        chk("rd_idle", icb_cmd_valid, 0);
        tick();
        tick();
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_rsp_vld", rd_rsp_vld, 2'b01);
        chk("rd_rsp_data", rd_rsp_data, 32'hDEAD_BEEF);
        chk("rd_rsp_ready", icb_rsp_ready, 1);
        tick();
        icb_rsp_valid = 1'b0;
        #1;
        chk("rd_outst0", outst_cnt, 0);
        chk("rd_rsp_vld_off", rd_rsp_vld, 0);

        // round robin from pointer 1 fills the FIFO: grants 1,0,1,0
        rd_req_vld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rdy", rd_req_rdy, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_addr", icb_cmd_addr, (k % 2 == 0) ? 32'h200 : 32'h100);
            tick();
        end
        #1;
        chk("full_outst", outst_cnt, 4);
        chk("full_valid", icb_cmd_valid, 0);
        chk("full_rdy", rd_req_rdy, 0);

        // pop while full: no bypass, new command only next cycle
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = 32'h0000_00A5;
        #1;
        chk("full_rsp_ready", icb_rsp_ready, 1);
        chk("full_rsp_vld", rd_rsp_vld, 2'b10);
        chk("full_nobypass", icb_cmd_valid, 0);
        tick();
        icb_rsp_valid = 1'b0;
        #1;
        chk("after_pop_outst", outst_cnt, 3);
        chk("after_pop_valid", icb_cmd_valid, 1);
        chk("after_pop_rdy", rd_req_rdy, 2'b10);
        tick();
        rd_req_vld = 2'b00;
        #1;
        chk("refill_outst", outst_cnt, 4);
        icb_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_route", rd_rsp_vld, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        icb_rsp_valid = 1'b0;
        #1;
        chk("drain_outst", outst_cnt, 0);

        // routing: ch1 read, priority write over ch0, then ch0 read
        rd_req_vld = 2'b10;
        #1;
        chk("route_ch1_rdy", rd_req_rdy, 2'b10);
        tick();
        rd_req_vld = 2'b01;
        wr_req_vld = 1'b1;
        #1;
        chk("wr_read", icb_cmd_read, 0);
        chk("wr_wmask", icb_cmd_wmask, 4'hF);
        chk("wr_wdata", icb_cmd_wdata, 32'h1234_5678);
        chk("wr_addr", icb_cmd_addr, 32'h300);
        chk("wr_rdy", wr_req_rdy, 1);
        chk("wr_rd_rdy", rd_req_rdy, 0);
        tick();
        wr_req_vld = 1'b0;
        #1;
        chk("route_ch0_rdy", rd_req_rdy, 2'b01);
        chk("route_ch0_wdata", icb_cmd_wdata, 0);
        tick();
        rd_req_vld = 2'b00;
        #1;
        chk("route_outst", outst_cnt, 3);
        rd_rsp_rdy    = 2'b01;
        icb_rsp_valid = 1'b1;
        icb_rsp_err   = 1'b1;
        #1;
        chk("route_stall_ready", icb_rsp_ready, 0);
        chk("route_stall_vld", rd_rsp_vld, 2'b10);
        tick();
        chk("route_stall_outst", outst_cnt, 3);
        chk("route_stall_err", err_sticky, 0);
        rd_rsp_rdy = 2'b11;
        #1;
        chk("route_ch1_ready", icb_rsp_ready, 1);
        chk("route_ch1_err", rd_rsp_err, 1);
        tick();
        icb_rsp_err = 1'b0;
        #1;
        chk("err_sticky", err_sticky, 1);
        chk("route_wr_vld", rd_rsp_vld, 0);
        chk("route_wr_done", wr_done, 1);
        chk("route_wr_ready", icb_rsp_ready, 1);
        tick();
        chk("route_done_off", wr_done, 0);
        chk("route_ch0_vld", rd_rsp_vld, 2'b01);
        tick();
        icb_rsp_valid = 1'b0;
        #1;
        chk("route_outst0", outst_cnt, 0);

        // lock: ch0 granted under backpressure, ch1 joins but grant holds
        rd_req_vld    = 2'b01;
        icb_cmd_ready = 1'b0;
        #1;
        chk("lock_valid", icb_cmd_valid, 1);
        chk("lock_addr0", icb_cmd_addr, 32'h100);
        tick();
        rd_req_vld = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("lock_hold_addr", icb_cmd_addr, 32'h100);
            chk("lock_hold_rdy", rd_req_rdy, 0);
            tick();
        end
        icb_cmd_ready = 1'b1;
        #1;
        chk("lock_release_rdy", rd_req_rdy, 2'b01);
        tick();
        chk("lock_next_rdy", rd_req_rdy, 2'b10);
        tick();
        rd_req_vld = 2'b01;
        #1;
        chk("lock_outst", outst_cnt, 2);
        tick();
        rd_req_vld = 2'b00;
        #1;
        chk("pre_reset_outst", outst_cnt, 3);

        // asynchronous reset with three outstanding
        #2 rst_n = 1'b0;
        icb_rsp_valid = 1'b1;
        #1;
        chk("areset_outst", outst_cnt, 0);
        chk("areset_rsp_ready", icb_rsp_ready, 0);
        chk("areset_err", err_sticky, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_rsp_ready", icb_rsp_ready, 0);
        chk("post_reset_rsp_vld", rd_rsp_vld, 0);
        chk("post_reset_outst", outst_cnt, 0);
        icb_rsp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
